// File: rtl/processor_pkg.sv
// processor_pkg
// Shared definitions for the multi-cycle processor core and its ALU:
// opcode and branch-condition encodings, FSM states, status-bit positions
// and the branch-condition evaluator.
package processor_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_STR = 4'h2;
    localparam logic [3:0] OP_BRA = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_ADD = 4'h5;
    localparam logic [3:0] OP_ROT = 4'h6;
    localparam logic [3:0] OP_SHF = 4'h7;
    localparam logic [3:0] OP_HLT = 4'h8;
    localparam logic [3:0] OP_CMP = 4'h9;

    localparam logic [3:0] CC_ALWAYS  = 4'h0;
    localparam logic [3:0] CC_PARITY  = 4'h1;
    localparam logic [3:0] CC_EVEN    = 4'h2;
    localparam logic [3:0] CC_CARRY   = 4'h3;
    localparam logic [3:0] CC_NEG     = 4'h4;
    localparam logic [3:0] CC_ZERO    = 4'h5;
    localparam logic [3:0] CC_NCARRY  = 4'h6;
    localparam logic [3:0] CC_POS     = 4'h7;

    // status = {zero, negative, even, parity, carry}
    localparam int ST_CARRY  = 0;
    localparam int ST_PARITY = 1;
    localparam int ST_EVEN   = 2;
    localparam int ST_NEG    = 3;
    localparam int ST_ZERO   = 4;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    // Codes 8-F are reserved and never taken.
    function automatic logic cc_true(input logic [3:0] cc, input logic [4:0] st);
        case (cc)
            CC_ALWAYS: cc_true = 1'b1;
            CC_PARITY: cc_true = st[ST_PARITY];
            CC_EVEN:   cc_true = st[ST_EVEN];
            CC_CARRY:  cc_true = st[ST_CARRY];
            CC_NEG:    cc_true = st[ST_NEG];
            CC_ZERO:   cc_true = st[ST_ZERO];
            CC_NCARRY: cc_true = ~st[ST_CARRY];
            CC_POS:    cc_true = ~st[ST_NEG] & ~st[ST_ZERO];
            default:   cc_true = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/processor_alu.sv
// processor_alu
// Combinational ALU for the multi-cycle processor.
// Ports:
//   op        in   4           opcode selecting the operation
//   a         in   DATA_WIDTH  destination register value
//   b         in   DATA_WIDTH  source operand (imm, register or memory data)
//   count     in   12          signed shift/rotate count, +left / -right
//   carry_in  in   1           current carry flag, passed through by non-ADD ops
//   result    out  DATA_WIDTH  value to write back
//   carry_out out  1           new carry flag
//   flags     out  4           {zero, negative, even, parity} of result
module processor_alu
    import processor_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [11:0]           count,
    input  logic                  carry_in,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry_out,
    output logic [3:0]            flags
);

    localparam logic [12:0] DW = 13'(DATA_WIDTH);

    logic [12:0]           mag;
    logic [12:0]           rot_amt;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] rotated;

    always_comb begin
        // 13 bits so that |-2048| is representable.
        mag     = count[11] ? (13'd0 - {count[11], count}) : {1'b0, count};
        rot_amt = mag % DW;
        sum     = {1'b0, a} + {1'b0, b};

        if (mag >= DW)
            shifted = '0;
        else if (count[11])
            shifted = a >> mag;
        else
            shifted = a << mag;

        // A zero rotate amount makes the complementary shift equal the width,
        // which yields zero, so the OR still returns a unchanged.
        if (count[11])
            rotated = (a >> rot_amt) | (a << (DW - rot_amt));
        else
            rotated = (a << rot_amt) | (a >> (DW - rot_amt));

        carry_out = carry_in;
        case (op)
            OP_LD:   result = b;
            OP_XOR:  result = a ^ b;
            OP_ADD:  begin
                result    = sum[DATA_WIDTH-1:0];
                carry_out = sum[DATA_WIDTH];
            end
            OP_ROT:  result = rotated;
            OP_SHF:  result = shifted;
            OP_CMP:  result = ~b;
            default: result = a;
        endcase

        flags = {~|result, result[DATA_WIDTH-1], ~result[0], ~^result};
    end

endmodule

// File: rtl/multicycle_processor.sv
// multicycle_processor
// Multi-cycle fetch/decode/execute CPU core with a register file, status
// flags, conditional branches and an external req/ready memory port.
// Ports:
//   clk        in   1           rising-edge clock
//   reset      in   1           synchronous, active-high
//   mem_req    out  1           transaction request, held until accepted
//   mem_we     out  1           1 = write, 0 = read
//   mem_addr   out  ADDR_WIDTH  transaction address
//   mem_wdata  out  DATA_WIDTH  write data
//   mem_rdata  in   DATA_WIDTH  read data, valid while mem_ready=1
//   mem_ready  in   1           transfer completes on edge with mem_req & mem_ready
//   pc         out  ADDR_WIDTH  program counter
//   status     out  5           {zero, negative, even, parity, carry}
//   halted     out  1           high in HALT state
//   illegal    out  1           sticky flag for opcodes 4'hA-4'hF
module multicycle_processor
    import processor_pkg::*;
#(
    parameter int         ADDR_WIDTH = 12,
    parameter int         DATA_WIDTH = 32,
    parameter int         NUM_REGS   = 16,
    parameter logic [11:0] RESET_PC  = 12'h100
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [4:0]            status,
    output logic                  halted,
    output logic                  illegal
);

    localparam int RW = $clog2(NUM_REGS);

    state_t                state, next_state;
    logic [31:0]           ir;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic [3:0]            op;
    logic                  use_imm;
    logic [RW-1:0]         dst_idx, src_idx;
    logic [ADDR_WIDTH-1:0] dst_addr, src_addr;
    logic [DATA_WIDTH-1:0] src_val, alu_b, alu_result;
    logic                  alu_carry;
    logic [3:0]            alu_flags;
    logic                  xfer_done, branch_taken, exec_needs_mem, exec_writes;

    logic                  mem_req_d, mem_we_d, reg_we;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;

    assign op        = ir[31:28];
    assign use_imm   = ir[27];
    assign dst_idx   = ir[RW-1:0];
    assign src_idx   = ir[12 +: RW];
    assign dst_addr  = ir[ADDR_WIDTH-1:0];
    assign src_addr  = ir[12 +: ADDR_WIDTH];
    assign src_val   = use_imm ? {{(DATA_WIDTH-12){1'b0}}, ir[23:12]} : regs[src_idx];
    // In MEM the only register write is LD, which passes memory data through
    // the ALU so the flags come from the same place as every other write.
    assign alu_b     = (state == S_MEM) ? mem_rdata : src_val;
    assign xfer_done = mem_req & mem_ready;

    assign branch_taken   = (op == OP_BRA) && cc_true(ir[27:24], status);
    assign exec_needs_mem = ((op == OP_LD) && !use_imm) || (op == OP_STR);
    assign exec_writes    = ((op == OP_LD) && use_imm) || (op == OP_XOR) ||
                            (op == OP_ADD) || (op == OP_ROT) ||
                            (op == OP_SHF) || (op == OP_CMP);

    processor_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op        (op),
        .a         (regs[dst_idx]),
        .b         (alu_b),
        .count     (ir[23:12]),
        .carry_in  (status[ST_CARRY]),
        .result    (alu_result),
        .carry_out (alu_carry),
        .flags     (alu_flags)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (xfer_done) next_state = S_DECODE;
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
                if (op == OP_HLT)
                    next_state = S_HALT;
                else if (exec_needs_mem)
                    next_state = S_MEM;
                else
                    next_state = S_FETCH;
            end
            S_MEM:    if (xfer_done) next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_FETCH;
        endcase
    end

    // Outputs: the memory port is registered, so each state computes the
    // request to present next cycle. EXEC and MEM launch the following fetch
    // directly, which keeps NOP at 3 cycles; only the first fetch after reset
    // needs FETCH to raise the request itself.
    always_comb begin
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        reg_we      = 1'b0;
        case (state)
            S_FETCH: begin
                if (xfer_done) begin
                    mem_req_d = 1'b0;
                end else if (!mem_req) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc;
                end
            end
            S_EXEC: begin
                reg_we = exec_writes;
                if (op == OP_HLT) begin
                    mem_req_d = 1'b0;
                end else if (exec_needs_mem) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = (op == OP_STR);
                    mem_addr_d  = (op == OP_STR) ? dst_addr : src_addr;
                    mem_wdata_d = src_val;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = branch_taken ? dst_addr : pc;
                end
            end
            S_MEM: begin
                if (xfer_done) begin
                    reg_we     = (op == OP_LD);
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc;
                end
            end
            S_HALT:  mem_req_d = 1'b0;
            default: mem_req_d = 1'b0;
        endcase
    end

    assign halted = (state == S_HALT);

    // Datapath: IR, PC, register file, status flags and memory port.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC[ADDR_WIDTH-1:0];
            ir        <= '0;
            status    <= '0;
            illegal   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if (state == S_FETCH && xfer_done) begin
                ir <= mem_rdata[31:0];
                pc <= pc + ADDR_WIDTH'(1);
            end
            if (state == S_EXEC && branch_taken)
                pc <= dst_addr;
            if (state == S_EXEC && op > OP_CMP)
                illegal <= 1'b1;
            if (reg_we) begin
                regs[dst_idx] <= alu_result;
                status        <= {alu_flags, alu_carry};
            end
        end
    end

endmodule

// File: tb/tb_multicycle_processor.sv
// tb_multicycle_processor
// Directed programs run from a bench memory model. Every expected memory
// transaction (fetch, data read, data write) is queued before a program
// starts; the memory model pops and compares as each transfer completes.
module tb_multicycle_processor;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [11:0] pc;
    logic [4:0]  status;
    logic        halted, illegal;

    logic [31:0] mem [4096];
    txn_t        exp_q [$];
    int          num_vec = 0;
    int          num_err = 0;
    int          wait_cycles = 0;
    int          req_age = 0;
    logic        held_we;
    logic [11:0] held_addr;
    logic [31:0] held_wdata;

    multicycle_processor dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .status    (status),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        num_vec++;
        if (act !== expv) begin
            num_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] mid,
                                       input logic [11:0] src, input logic [11:0] dst);
        return {op, mid, src, dst};
    endfunction

    task automatic expF(input logic [11:0] a);
        exp_q.push_back('{1'b0, a, 32'h0});
    endtask

    task automatic expW(input logic [11:0] a, input logic [31:0] d);
        exp_q.push_back('{1'b1, a, d});
    endtask

    // Memory model and scoreboard monitor: decides ready on the falling edge,
    // so the transfer completes on the following rising edge.
    always @(negedge clk) begin
        txn_t e;
        if (mem_req === 1'b1) begin
            if (req_age == 0) begin
                held_we    = mem_we;
                held_addr  = mem_addr;
                held_wdata = mem_wdata;
            end else begin
                cmp("request stable", {mem_we, mem_addr, mem_wdata[18:0]},
                    {held_we, held_addr, held_wdata[18:0]});
                cmp("wdata stable", mem_wdata, held_wdata);
            end
            if (req_age >= wait_cycles) begin
                mem_ready = 1'b1;
                if (exp_q.size() == 0) begin
                    num_vec++;
                    num_err++;
                    $display("[TB] FAIL unexpected txn: got we=%0b addr=%0h, expected none",
                             mem_we, mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    cmp("txn we", {31'h0, mem_we}, {31'h0, e.we});
                    cmp("txn addr", {20'h0, mem_addr}, {20'h0, e.addr});
                    if (e.we)
                        cmp("txn wdata", mem_wdata, e.data);
                end
                if (!mem_we)
                    mem_rdata = mem[mem_addr];
                req_age = 0;
            end else begin
                mem_ready = 1'b0;
                req_age++;
            end
        end else begin
            mem_ready = 1'b0;
            req_age   = 0;
        end
    end

    task automatic loadProgram(input int prog);
        for (int i = 0; i < 4096; i++)
            mem[i] = 32'h0;
        if (prog == 1) begin
            mem[12'h300] = 32'hFFFF_FFFF;
            mem[12'h100] = ins(4'h1, 4'h8, 12'h005, 12'h001);  // LD r1,#5
            mem[12'h101] = ins(4'h5, 4'h8, 12'hFFF, 12'h001);  // ADD r1,#FFF
            mem[12'h102] = ins(4'h3, 4'h1, 12'h000, 12'h104);  // BRA parity
            mem[12'h103] = ins(4'h2, 4'h8, 12'hBAD, 12'h2FE);
            mem[12'h104] = ins(4'h2, 4'h0, 12'h001, 12'h200);  // STR [200],r1
            mem[12'h105] = ins(4'h1, 4'h8, 12'hFFF, 12'h002);  // LD r2,#FFF
            mem[12'h106] = ins(4'h1, 4'h0, 12'h300, 12'h003);  // LD r3,[300]
            mem[12'h107] = ins(4'h5, 4'h0, 12'h002, 12'h003);  // ADD r3,r2
            mem[12'h108] = ins(4'h2, 4'h0, 12'h003, 12'h201);  // STR [201],r3
            mem[12'h109] = ins(4'h3, 4'h3, 12'h000, 12'h10C);  // BRA carry
            mem[12'h10A] = ins(4'h2, 4'h8, 12'hBAD, 12'h2FF);
            mem[12'h10B] = ins(4'h8, 4'h0, 12'h000, 12'h000);
            mem[12'h10C] = ins(4'h3, 4'h6, 12'h000, 12'h10A);  // BRA ~carry
            mem[12'h10D] = ins(4'h8, 4'h0, 12'h000, 12'h000);  // HLT
            expF(12'h100); expF(12'h101); expF(12'h102); expF(12'h104);
            expW(12'h200, 32'h0000_1004);
            expF(12'h105); expF(12'h106); expF(12'h300); expF(12'h107);
            expF(12'h108); expW(12'h201, 32'h0000_0FFE);
            expF(12'h109); expF(12'h10C); expF(12'h10D);
        end else begin
            mem[12'h300] = 32'h8000_0001;
            mem[12'h100] = ins(4'h1, 4'h0, 12'h300, 12'h004);  // LD r4,[300]
            mem[12'h101] = ins(4'h7, 4'h0, 12'hFFF, 12'h004);  // SHF r4,-1
            mem[12'h102] = ins(4'h2, 4'h0, 12'h004, 12'h210);
            mem[12'h103] = ins(4'h1, 4'h0, 12'h300, 12'h005);  // LD r5,[300]
            mem[12'h104] = ins(4'h6, 4'h0, 12'h001, 12'h005);  // ROT r5,+1
            mem[12'h105] = ins(4'h2, 4'h0, 12'h005, 12'h211);
            mem[12'h106] = ins(4'h6, 4'h0, 12'hFFE, 12'h005);  // ROT r5,-2
            mem[12'h107] = ins(4'h2, 4'h0, 12'h005, 12'h212);
            mem[12'h108] = ins(4'h7, 4'h0, 12'h020, 12'h005);  // SHF r5,32
            mem[12'h109] = ins(4'h2, 4'h0, 12'h005, 12'h213);
            mem[12'h10A] = ins(4'h3, 4'h5, 12'h000, 12'h10D);  // BRA zero
            mem[12'h10B] = ins(4'h8, 4'h0, 12'h000, 12'h000);
            mem[12'h10C] = ins(4'h8, 4'h0, 12'h000, 12'h000);
            mem[12'h10D] = ins(4'h9, 4'h8, 12'h000, 12'h006);  // CMP r6,#0
            mem[12'h10E] = ins(4'h3, 4'h7, 12'h000, 12'h10B);  // BRA positive
            mem[12'h10F] = ins(4'h3, 4'h8, 12'h000, 12'h10B);  // BRA never
            mem[12'h110] = ins(4'hB, 4'h0, 12'h000, 12'h000);  // illegal
            mem[12'h111] = ins(4'h3, 4'h0, 12'h000, 12'h113);  // BRA always
            mem[12'h112] = ins(4'h8, 4'h0, 12'h000, 12'h000);
            mem[12'h113] = ins(4'h1, 4'h8, 12'h001, 12'h007);  // LD r7,#1
            mem[12'h114] = ins(4'h6, 4'h0, 12'h021, 12'h007);  // ROT r7,33
            mem[12'h115] = ins(4'h2, 4'h0, 12'h007, 12'h214);
            mem[12'h116] = ins(4'h8, 4'h0, 12'h000, 12'h000);  // HLT
            expF(12'h100); expF(12'h300); expF(12'h101); expF(12'h102);
            expW(12'h210, 32'h4000_0000);
            expF(12'h103); expF(12'h300); expF(12'h104); expF(12'h105);
            expW(12'h211, 32'h0000_0003);
            expF(12'h106); expF(12'h107); expW(12'h212, 32'hC000_0000);
            expF(12'h108); expF(12'h109); expW(12'h213, 32'h0000_0000);
            expF(12'h10A); expF(12'h10D); expF(12'h10E); expF(12'h10F);
            expF(12'h110); expF(12'h111); expF(12'h113); expF(12'h114);
            expF(12'h115); expW(12'h214, 32'h0000_0002); expF(12'h116);
        end
    endtask

    // Loads a program, resets the core and checks the reset state and the
    // first fetch request.
    task automatic applyStimulus(input int prog, input int waits);
        wait_cycles = waits;
        loadProgram(prog);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        cmp("reset mem_req", {31'h0, mem_req}, 32'h0);
        cmp("reset pc", {20'h0, pc}, 32'h100);
        cmp("reset status", {27'h0, status}, 32'h0);
        cmp("reset halted", {31'h0, halted}, 32'h0);
        cmp("reset illegal", {31'h0, illegal}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        cmp("first req", {31'h0, mem_req}, 32'h1);
        cmp("first addr", {20'h0, mem_addr}, 32'h100);
    endtask

    // Waits (bounded) for HALT, then checks final architectural state and
    // that the core stays quiet.
    task automatic checkOutput(input logic [11:0] exp_pc, input logic [4:0] exp_status,
                               input logic exp_illegal);
        int cyc = 0;
        while (halted !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        cmp("halt reached", {31'h0, halted}, 32'h1);
        repeat (5) @(negedge clk);
        cmp("halt mem_req", {31'h0, mem_req}, 32'h0);
        cmp("final pc", {20'h0, pc}, {20'h0, exp_pc});
        cmp("final status", {27'h0, status}, {27'h0, exp_status});
        cmp("final illegal", {31'h0, illegal}, {31'h0, exp_illegal});
        cmp("scoreboard drained", exp_q.size(), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);

        applyStimulus(1, 0);
        checkOutput(12'h10E, 5'b00101, 1'b0);

        applyStimulus(2, 0);
        checkOutput(12'h117, 5'b00100, 1'b1);

        applyStimulus(1, 3);
        checkOutput(12'h10E, 5'b00101, 1'b0);

        // Reset while a fetch is still waiting for ready.
        begin
            int cyc = 0;
            wait_cycles = 1000;
            loadProgram(1);
            @(negedge clk);
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
            while (mem_req !== 1'b1 && cyc < 10) begin
                @(negedge clk);
                cyc++;
            end
            cmp("wait req raised", {31'h0, mem_req}, 32'h1);
            repeat (2) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            cmp("req dropped after reset", {31'h0, mem_req}, 32'h0);
            cmp("pc after abort", {20'h0, pc}, 32'h100);
            exp_q.delete();
        end

        $display("== %0d vectors applied, %0d miscompares ==", num_vec, num_err);
        $finish;
    end

endmodule
